// File: rtl/display_scan_ctrl.sv
// Display refresh/scan controller: frame-aligned commit of received words,
// digit-select scan with blanking slot, stale and overrun flags.
module display_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYC    = 16,
    parameter int STALE_FRAMES = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [9:0] rx_word,
    input  logic       rx_ten,
    output logic [7:0] disp_data,
    output logic [1:0] disp_ext,
    output logic       disp_ten,
    output logic [1:0] digit_sel,
    output logic       frame_tick,
    output logic       stale,
    output logic       overrun
);

    localparam int MAXC = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int FW   = $clog2(STALE_FRAMES + 1);

    localparam logic [CW-1:0] R_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] B_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [FW-1:0] S_MAX  = FW'(STALE_FRAMES);

    typedef enum logic [0:0] {
        DIGIT,
        BLANK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          pending;
    logic [10:0]   shadow;
    logic [FW-1:0] fcnt;

    logic       adv;
    logic       wrap;
    logic [1:0] last_idx;

    always_comb begin
        adv      = 1'b0;
        last_idx = disp_ten ? 2'd2 : 2'd1;
        unique case (state)
            DIGIT: adv = (cnt == R_LAST) && (BLANK_CYC == 0);
            BLANK: adv = (cnt == B_LAST);
            default: adv = 1'b0;
        endcase
        wrap = adv && (idx == last_idx);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= DIGIT;
            cnt        <= '0;
            idx        <= 2'd0;
            digit_sel  <= 2'd0;
            disp_data  <= 8'd0;
            disp_ext   <= 2'd0;
            disp_ten   <= 1'b0;
            frame_tick <= 1'b0;
            stale      <= 1'b0;
            overrun    <= 1'b0;
            pending    <= 1'b0;
            shadow     <= '0;
            fcnt       <= '0;
        end else begin
            frame_tick <= 1'b0;
            overrun    <= 1'b0;

            unique case (state)
                DIGIT: begin
                    if (cnt == R_LAST) begin
                        cnt <= '0;
                        if (BLANK_CYC != 0) begin
                            state     <= BLANK;
                            digit_sel <= 2'd3;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BLANK: begin
                    if (cnt == B_LAST) begin
                        cnt   <= '0;
                        state <= DIGIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= DIGIT;
            endcase

            if (adv) begin
                if (wrap) begin
                    idx        <= 2'd0;
                    digit_sel  <= 2'd0;
                    frame_tick <= 1'b1;
                    if (pending) begin
                        disp_data <= shadow[7:0];
                        disp_ext  <= shadow[10] ? shadow[9:8] : 2'd0;
                        disp_ten  <= shadow[10];
                        pending   <= 1'b0;
                        stale     <= 1'b0;
                        fcnt      <= '0;
                    end else if (fcnt != S_MAX) begin
                        fcnt <= fcnt + 1'b1;
                        if (fcnt + 1'b1 == S_MAX)
                            stale <= 1'b1;
                    end
                end else begin
                    idx       <= idx + 2'd1;
                    digit_sel <= idx + 2'd1;
                end
            end

            // Capture after commit so a word arriving on the boundary stays pending.
            if (rx_valid) begin
                shadow  <= {rx_ten, rx_word};
                pending <= 1'b1;
                overrun <= pending;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: vector table, directed corner sequences,
// and randomized traffic against a frame-position reference model.
module tb_display_scan_ctrl;

    localparam int R = 4;
    localparam int B = 2;
    localparam int S = 3;
    localparam int SLOT = R + B;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [9:0] rx_word = '0;
    logic       rx_ten = 1'b0;
    logic [7:0] disp_data;
    logic [1:0] disp_ext;
    logic       disp_ten;
    logic [1:0] digit_sel;
    logic       frame_tick;
    logic       stale;
    logic       overrun;

    display_scan_ctrl #(
        .REFRESH_DIV (R),
        .BLANK_CYC   (B),
        .STALE_FRAMES(S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_word   (rx_word),
        .rx_ten    (rx_ten),
        .disp_data (disp_data),
        .disp_ext  (disp_ext),
        .disp_ten  (disp_ten),
        .digit_sel (digit_sel),
        .frame_tick(frame_tick),
        .stale     (stale),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: position within the frame plus committed/pending words.
    int         m_pos;
    int         m_n;
    logic [7:0] m_data;
    logic [1:0] m_ext;
    logic       m_ten;
    logic       m_tick;
    logic       m_stale;
    logic       m_over;
    logic       m_pend;
    logic [10:0] m_shadow;
    int         m_fc;

    typedef struct {
        logic       r;
        logic       v;
        logic [9:0] w;
        logic       t;
        logic [1:0] sel;
        logic       tick;
        logic [7:0] data;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_sel();
        if ((m_pos % SLOT) < R)
            return 2'(m_pos / SLOT);
        return 2'd3;
    endfunction

    task automatic model(input logic r, input logic v, input logic [9:0] w,
                         input logic t);
        if (!r) begin
            m_pos = 0; m_n = 2; m_data = 0; m_ext = 0; m_ten = 0;
            m_tick = 0; m_stale = 0; m_over = 0; m_pend = 0;
            m_shadow = 0; m_fc = 0;
        end else begin
            m_over = v && m_pend;
            m_tick = 1'b0;
            m_pos++;
            if (m_pos == m_n * SLOT) begin
                m_pos = 0;
                m_tick = 1'b1;
                if (m_pend) begin
                    m_data = m_shadow[7:0];
                    m_ext = m_shadow[10] ? m_shadow[9:8] : 2'd0;
                    m_ten = m_shadow[10];
                    m_pend = 1'b0;
                    m_stale = 1'b0;
                    m_fc = 0;
                end else begin
                    if (m_fc < S) m_fc++;
                    if (m_fc == S) m_stale = 1'b1;
                end
                m_n = m_ten ? 3 : 2;
            end
            if (v) begin
                m_shadow = {t, w};
                m_pend = 1'b1;
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [9:0] w,
                        input logic t);
        @(negedge clk);
        rst_n = r; rx_valid = v; rx_word = w; rx_ten = t;
        @(posedge clk);
        model(r, v, w, t);
        #1;
        chk("digit_sel", 32'(digit_sel), 32'(m_sel()));
        chk("frame_tick", 32'(frame_tick), 32'(m_tick));
        chk("disp_data", 32'(disp_data), 32'(m_data));
        chk("disp_ext", 32'(disp_ext), 32'(m_ext));
        chk("disp_ten", 32'(disp_ten), 32'(m_ten));
        chk("stale", 32'(stale), 32'(m_stale));
        chk("overrun", 32'(overrun), 32'(m_over));
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 10'd0, 1'b0);
    endtask

    task automatic wait_tick(output int cyc, output logic seen2);
        logic found;
        found = 1'b0;
        seen2 = 1'b0;
        cyc = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            idle();
            cyc++;
            if (digit_sel == 2'd2) seen2 = 1'b1;
            if (frame_tick) found = 1'b1;
        end
        chk("tick_timeout", 32'(found), 32'd1);
    endtask

    initial begin
        int   cyc;
        logic s2;
        logic found;

        for (int i = 0; i < 14; i++)
            vt[i] = '{1'b1, 1'b0, 10'd0, 1'b0, 2'd0, 1'b0, 8'h00};
        vt[0].r = 1'b0;
        vt[4].sel = 2'd3;  vt[5].sel = 2'd3;
        vt[6].sel = 2'd1;  vt[7].sel = 2'd1;
        vt[8].sel = 2'd1;  vt[9].sel = 2'd1;
        vt[10].sel = 2'd3; vt[11].sel = 2'd3;
        vt[7].v = 1'b1;    vt[7].w = 10'h3A5;
        vt[12].tick = 1'b1;
        vt[12].data = 8'hA5; vt[13].data = 8'hA5;

        for (int i = 0; i < 14; i++) begin
            step(vt[i].r, vt[i].v, vt[i].w, vt[i].t);
            chk("vec_sel", 32'(digit_sel), 32'(vt[i].sel));
            chk("vec_tick", 32'(frame_tick), 32'(vt[i].tick));
            chk("vec_data", 32'(disp_data), 32'(vt[i].data));
            chk("vec_ext", 32'(disp_ext), 32'd0);
        end

        // 10-bit word: three digits, 18-cycle frame
        step(1'b1, 1'b1, 10'h2C7, 1'b1);
        wait_tick(cyc, s2);
        chk("ten_data", 32'(disp_data), 32'hC7);
        chk("ten_ext", 32'(disp_ext), 32'd2);
        chk("ten_flag", 32'(disp_ten), 32'd1);
        wait_tick(cyc, s2);
        chk("ten_period", 32'(cyc), 32'd18);
        chk("ten_digit2", 32'(s2), 32'd1);

        // overrun on second capture within a frame, last word wins
        step(1'b1, 1'b1, 10'h011, 1'b0);
        chk("ovr_first", 32'(overrun), 32'd0);
        step(1'b1, 1'b1, 10'h022, 1'b0);
        chk("ovr_second", 32'(overrun), 32'd1);
        idle();
        chk("ovr_pulse", 32'(overrun), 32'd0);
        wait_tick(cyc, s2);
        chk("ovr_data", 32'(disp_data), 32'h22);
        chk("ovr_ten", 32'(disp_ten), 32'd0);
        wait_tick(cyc, s2);
        chk("eight_period", 32'(cyc), 32'd12);

        // stale after three frames without a commit
        chk("stale_f1", 32'(stale), 32'd0);
        wait_tick(cyc, s2);
        chk("stale_f2", 32'(stale), 32'd0);
        wait_tick(cyc, s2);
        chk("stale_f3", 32'(stale), 32'd1);
        step(1'b1, 1'b1, 10'h055, 1'b0);
        chk("stale_hold", 32'(stale), 32'd1);
        wait_tick(cyc, s2);
        chk("stale_clr", 32'(stale), 32'd0);
        chk("stale_data", 32'(disp_data), 32'h55);

        // reset mid-frame during digit 1 with a pending word
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            idle();
            if (digit_sel == 2'd1) found = 1'b1;
        end
        chk("find_digit1", 32'(found), 32'd1);
        step(1'b1, 1'b1, 10'h0AB, 1'b0);
        step(1'b0, 1'b0, 10'd0, 1'b0);
        chk("rst_sel", 32'(digit_sel), 32'd0);
        chk("rst_data", 32'(disp_data), 32'd0);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        wait_tick(cyc, s2);
        chk("rst_period", 32'(cyc), 32'd12);
        chk("rst_discard", 32'(disp_data), 32'd0);

        // capture on the commit edge
        step(1'b1, 1'b1, 10'h0BE, 1'b0);
        for (int k = 0; k < 40 && m_pos != m_n * SLOT - 1; k++)
            idle();
        chk("find_edge", 32'(m_pos), 32'(m_n * SLOT - 1));
        step(1'b1, 1'b1, 10'h0CD, 1'b0);
        chk("edge_tick", 32'(frame_tick), 32'd1);
        chk("edge_old", 32'(disp_data), 32'hBE);
        chk("edge_ovr", 32'(overrun), 32'd1);
        wait_tick(cyc, s2);
        chk("edge_new", 32'(disp_data), 32'hCD);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic r;
            logic v;
            r = ($urandom_range(0, 399) != 0);
            v = ($urandom_range(0, 14) == 0);
            step(r, v, 10'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
